// File: rtl/common_def.sv
// Shared definitions for the ALU reservation station: bus widths, tag encoding,
// ALU opcodes and the station entry record.
package common_def;

  localparam int DATA_W   = 32;
  localparam int TAG_W    = 4;
  localparam int OP_MAX_W = 8;
  localparam logic [TAG_W-1:0] TAG_INVALID = 4'd0;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_SLL  = 5'd5,
    OP_SRL  = 5'd6,
    OP_SRA  = 5'd7,
    OP_SLT  = 5'd8,
    OP_SLTU = 5'd9
  } alu_op_e;

  // op is held at the widest supported opcode width; stations narrow it on dispatch.
  typedef struct packed {
    logic                busy;
    logic [OP_MAX_W-1:0] op;
    logic [TAG_W-1:0]    q1;
    logic [DATA_W-1:0]   v1;
    logic [TAG_W-1:0]    q2;
    logic [DATA_W-1:0]   v2;
    logic [TAG_W-1:0]    dest;
  } rs_entry_t;

  localparam rs_entry_t RS_ENTRY_EMPTY = '{
    busy: 1'b0, op: '0, q1: TAG_INVALID, v1: '0, q2: TAG_INVALID, v2: '0, dest: '0
  };

  function automatic logic entry_ready(input rs_entry_t e);
    return e.busy && (e.q1 == TAG_INVALID) && (e.q2 == TAG_INVALID);
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Issue, broadcast and dispatch signals of the ALU reservation station.
// master = decoder/CDB/ALU side, slave = the station itself.
interface alu_rs_if
  import common_def::*;
#(
  parameter int OP_W = 5
);
  logic              flush;
  logic              issue_valid;
  logic [OP_W-1:0]   issue_op;
  logic [TAG_W-1:0]  issue_tag1;
  logic [TAG_W-1:0]  issue_tag2;
  logic [DATA_W-1:0] issue_src1;
  logic [DATA_W-1:0] issue_src2;
  logic [TAG_W-1:0]  issue_dest_tag;
  logic              full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              ex_valid;
  logic [OP_W-1:0]   ex_op;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [TAG_W-1:0]  ex_dest_tag;
  logic              ex_ready;

  modport master (
    output flush, issue_valid, issue_op, issue_tag1, issue_tag2, issue_src1, issue_src2,
           issue_dest_tag, cdb_valid, cdb_tag, cdb_data, ex_ready,
    input  full, ex_valid, ex_op, ex_a, ex_b, ex_dest_tag
  );

  modport slave (
    input  flush, issue_valid, issue_op, issue_tag1, issue_tag2, issue_src1, issue_src2,
           issue_dest_tag, cdb_valid, cdb_tag, cdb_data, ex_ready,
    output full, ex_valid, ex_op, ex_a, ex_b, ex_dest_tag
  );
endinterface

// File: rtl/rs_select.sv
// Priority encoder: index of the lowest set request bit, plus a hit flag.
module rs_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         req,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     hit
);
  localparam int IDX_W = $clog2(DEPTH);

  // NOTE: both outputs get a default before the loop so no path leaves them unassigned (no latch).
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued instructions until both operands are
// captured from the register file or the CDB, then dispatches the lowest ready entry.
module alu_rs
  import common_def::*;
#(
  parameter int DEPTH = 4,
  parameter int OP_W  = 5
) (
  input logic     clk,
  input logic     rst,
  alu_rs_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t        rs [DEPTH];
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] idle;
  logic [IDX_W-1:0] ex_idx;
  logic [IDX_W-1:0] free_idx;
  logic             ex_hit;
  logic             free_hit;
  logic             issue_acc;
  logic             dispatch;
  logic             cdb_live;
  logic             byp1;
  logic             byp2;
  rs_entry_t        new_entry;

  always_comb begin
    ready = '0;
    idle  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = entry_ready(rs[i]);
      idle[i]  = !rs[i].busy;
    end
  end

  rs_select #(.DEPTH(DEPTH)) u_sel_ready (.req(ready), .idx(ex_idx),   .hit(ex_hit));
  rs_select #(.DEPTH(DEPTH)) u_sel_free  (.req(idle),  .idx(free_idx), .hit(free_hit));

  // Full and the free slot come from registered busy bits only, so a slot
  // released by this cycle's dispatch is reused no earlier than next cycle.
  assign bus.full  = !free_hit;
  assign issue_acc = bus.issue_valid && free_hit;
  assign dispatch  = ex_hit && bus.ex_ready;
  assign cdb_live  = bus.cdb_valid && (bus.cdb_tag != TAG_INVALID);
  assign byp1      = cdb_live && (bus.issue_tag1 == bus.cdb_tag);
  assign byp2      = cdb_live && (bus.issue_tag2 == bus.cdb_tag);

  always_comb begin
    new_entry      = RS_ENTRY_EMPTY;
    new_entry.busy = 1'b1;
    new_entry.op   = OP_MAX_W'(bus.issue_op);
    new_entry.q1   = byp1 ? TAG_INVALID  : bus.issue_tag1;
    new_entry.v1   = byp1 ? bus.cdb_data : bus.issue_src1;
    new_entry.q2   = byp2 ? TAG_INVALID  : bus.issue_tag2;
    new_entry.v2   = byp2 ? bus.cdb_data : bus.issue_src2;
    new_entry.dest = bus.issue_dest_tag;
  end

  always_comb begin
    bus.ex_valid    = ex_hit;
    bus.ex_op       = '0;
    bus.ex_a        = '0;
    bus.ex_b        = '0;
    bus.ex_dest_tag = '0;
    if (ex_hit) begin
      bus.ex_op       = rs[ex_idx].op[OP_W-1:0];
      bus.ex_a        = rs[ex_idx].v1;
      bus.ex_b        = rs[ex_idx].v2;
      bus.ex_dest_tag = rs[ex_idx].dest;
    end
  end

  // NOTE: the entry array is control state (busy/tags), so every entry is reset, not just a valid bit.
  // NOTE: sequential state uses non-blocking assignments so all entries update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) rs[i] <= RS_ENTRY_EMPTY;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) rs[i] <= RS_ENTRY_EMPTY;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_acc && (free_idx == IDX_W'(i))) begin
          rs[i] <= new_entry;
        end else begin
          if (cdb_live && rs[i].busy && (rs[i].q1 == bus.cdb_tag)) begin
            rs[i].q1 <= TAG_INVALID;
            rs[i].v1 <= bus.cdb_data;
          end
          if (cdb_live && rs[i].busy && (rs[i].q2 == bus.cdb_tag)) begin
            rs[i].q2 <= TAG_INVALID;
            rs[i].v2 <= bus.cdb_data;
          end
          if (dispatch && (ex_idx == IDX_W'(i))) rs[i].busy <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: stimulus pushes expected dispatches into a queue,
// a negedge monitor pops and compares every accepted dispatch.
module tb_alu_rs;
  import common_def::*;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  dest;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_rs_if #(.OP_W(5)) bus ();

  alu_rs #(.DEPTH(4), .OP_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
    bus.cdb_valid   = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic issue(input alu_op_e op, input logic [3:0] t1, input logic [31:0] s1,
                       input logic [3:0] t2, input logic [31:0] s2, input logic [3:0] dest);
    bus.issue_valid    = 1'b1;
    bus.issue_op       = op;
    bus.issue_tag1     = t1;
    bus.issue_src1     = s1;
    bus.issue_tag2     = t2;
    bus.issue_src2     = s2;
    bus.issue_dest_tag = dest;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] d);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = t;
    bus.cdb_data  = d;
  endtask

  task automatic expect_ex(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] dest);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.dest = dest;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && bus.ex_valid && bus.ex_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected dispatch: got dest %0d, required none", bus.ex_dest_tag);
      end else begin
        e = sb.pop_front();
        check("ex_op",       32'(bus.ex_op),       32'(e.op));
        check("ex_a",        bus.ex_a,             e.a);
        check("ex_b",        bus.ex_b,             e.b);
        check("ex_dest_tag", 32'(bus.ex_dest_tag), 32'(e.dest));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.flush = 0; bus.issue_valid = 0; bus.issue_op = '0;
    bus.issue_tag1 = '0; bus.issue_tag2 = '0; bus.issue_src1 = '0; bus.issue_src2 = '0;
    bus.issue_dest_tag = '0; bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.ex_ready = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("reset full",     32'(bus.full),     0);
    check("reset ex_valid", 32'(bus.ex_valid), 0);
    check("reset ex_a",     bus.ex_a,          0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Ready-at-issue instruction dispatches the next cycle and frees its slot.
    bus.ex_ready = 1'b1;
    issue(OP_ADD, 4'd0, 32'd5, 4'd0, 32'd7, 4'd1);
    expect_ex(OP_ADD, 32'd5, 32'd7, 4'd1);
    tick();
    check("add ex_valid", 32'(bus.ex_valid), 1);
    tick();
    check("add freed", 32'(bus.ex_valid), 0);

    // Wake-up from a CDB broadcast, visible one cycle later.
    issue(OP_SUB, 4'd3, 32'hBAD, 4'd0, 32'd2, 4'd2);
    tick();
    check("sub waiting", 32'(bus.ex_valid), 0);
    cdb(4'd3, 32'h10);
    expect_ex(OP_SUB, 32'h10, 32'd2, 4'd2);
    check("sub broadcast cycle", 32'(bus.ex_valid), 0);
    tick();
    check("sub woken", 32'(bus.ex_valid), 1);
    check("sub ex_a", bus.ex_a, 32'h10);
    tick();

    // Issue-cycle bypass of the broadcast into operand 2.
    issue(OP_AND, 4'd0, 32'hF0, 4'd5, 32'hDEAD, 4'd3);
    cdb(4'd5, 32'd9);
    expect_ex(OP_AND, 32'hF0, 32'd9, 4'd3);
    tick();
    check("and bypass ex_valid", 32'(bus.ex_valid), 1);
    check("and bypass ex_b", bus.ex_b, 32'd9);
    tick();

    // Both operands waiting on the same tag wake together.
    issue(OP_OR, 4'd6, 32'd0, 4'd6, 32'd0, 4'd4);
    tick();
    cdb(4'd6, 32'h33);
    expect_ex(OP_OR, 32'h33, 32'h33, 4'd4);
    tick();
    check("or dual wake", 32'(bus.ex_valid), 1);
    tick();
    check("or freed", 32'(bus.ex_valid), 0);

    // Fill the station, drop a fifth issue, then reuse the freed slot.
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(OP_SLL, 4'(7 + i), 32'd0, 4'd0, 32'(i + 1), 4'(5 + i));
      tick();
    end
    check("fill full", 32'(bus.full), 1);
    issue(OP_XOR, 4'd0, 32'hA, 4'd0, 32'hB, 4'd9);
    tick();
    check("fifth ignored full", 32'(bus.full), 1);
    check("fifth ignored ex_valid", 32'(bus.ex_valid), 0);
    cdb(4'd8, 32'h80);
    tick();
    check("entry1 woken", 32'(bus.ex_dest_tag), 6);
    bus.ex_ready = 1'b1;
    expect_ex(OP_SLL, 32'h80, 32'd2, 4'd6);
    check("full during dispatch", 32'(bus.full), 1);
    tick();
    bus.ex_ready = 1'b0;
    check("full after dispatch", 32'(bus.full), 0);
    issue(OP_XOR, 4'd0, 32'hA, 4'd0, 32'hB, 4'd9);
    tick();
    check("fifth lands full", 32'(bus.full), 1);
    check("fifth lands dest", 32'(bus.ex_dest_tag), 9);
    expect_ex(OP_XOR, 32'hA, 32'hB, 4'd9);
    bus.ex_ready = 1'b1;
    tick();
    bus.ex_ready = 1'b0;
    check("rest waiting", 32'(bus.ex_valid), 0);

    // Flush clears waiting entries; a later matching broadcast must not revive them.
    bus.flush = 1'b1;
    tick();
    check("flush full", 32'(bus.full), 0);
    check("flush ex_valid", 32'(bus.ex_valid), 0);
    cdb(4'd7, 32'd1);
    tick();
    check("no wake after flush", 32'(bus.ex_valid), 0);

    // Entries 1 and 3 ready, 0 and 2 waiting: 1 goes first, then 3.
    issue(OP_ADD,  4'd11, 32'd0,  4'd0, 32'd1, 4'd10); tick();
    issue(OP_SUB,  4'd0,  32'd20, 4'd0, 32'd3, 4'd11); tick();
    issue(OP_OR,   4'd12, 32'd0,  4'd0, 32'd0, 4'd12); tick();
    issue(OP_SLT,  4'd0,  32'd1,  4'd0, 32'd2, 4'd13); tick();
    check("prio full", 32'(bus.full), 1);
    check("prio first", 32'(bus.ex_dest_tag), 11);
    expect_ex(OP_SUB, 32'd20, 32'd3, 4'd11);
    expect_ex(OP_SLT, 32'd1, 32'd2, 4'd13);
    bus.ex_ready = 1'b1;
    tick();
    check("prio second", 32'(bus.ex_dest_tag), 13);
    tick();
    bus.ex_ready = 1'b0;
    check("prio only waiting", 32'(bus.ex_valid), 0);

    // Flush wins over a simultaneous issue with three entries busy.
    issue(OP_AND, 4'd14, 32'd0, 4'd0, 32'd0, 4'd14);
    tick();
    bus.flush = 1'b1;
    issue(OP_ADD, 4'd0, 32'd1, 4'd0, 32'd1, 4'd15);
    tick();
    check("flush+issue full", 32'(bus.full), 0);
    check("flush+issue ex_valid", 32'(bus.ex_valid), 0);

    // Asynchronous reset mid-stream, then a fresh issue.
    issue(OP_ADD, 4'd0, 32'd7, 4'd0, 32'd8, 4'd1); tick();
    issue(OP_SUB, 4'd3, 32'd0, 4'd0, 32'd0, 4'd2); tick();
    check("pre-reset ex_valid", 32'(bus.ex_valid), 1);
    #2 rst = 1'b0;
    #1;
    check("async reset ex_valid", 32'(bus.ex_valid), 0);
    check("async reset full", 32'(bus.full), 0);
    check("async reset ex_a", bus.ex_a, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.ex_ready = 1'b1;
    issue(OP_XOR, 4'd0, 32'd3, 4'd0, 32'd5, 4'd7);
    expect_ex(OP_XOR, 32'd3, 32'd5, 4'd7);
    tick();
    check("post-reset dest", 32'(bus.ex_dest_tag), 7);
    tick();
    check("post-reset drained", 32'(bus.ex_valid), 0);

    check("scoreboard empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter DEPTH, default 4, number of station entries (2..8).
REQ-002 Parameter OP_W, default 5, ALU opcode width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 flush  in  1  synchronous clear of all entries (mispredict).
REQ-006 issue_valid  in  1  decoder presents an instruction this cycle.
REQ-007 issue_op  in  OP_W  ALU opcode.
REQ-008 issue_tag1/issue_tag2  in  TAG_W each  operand producer tags from register file; TAG_INVALID means value present.
REQ-009 issue_src1/issue_src2  in  DATA_W each  operand values from register file.
REQ-010 issue_dest_tag  in  TAG_W  tag this instruction will broadcast.
REQ-011 full  out  1  no free entry; issue ignored while high.
REQ-012 cdb_valid  in  1  common data bus broadcast valid.
REQ-013 cdb_tag  in  TAG_W; cdb_data  in  DATA_W  broadcast result.
REQ-014 ex_valid  out  1  an entry is ready for the ALU.
REQ-015 ex_op  out  OP_W; ex_a/ex_b  out  DATA_W; ex_dest_tag  out  TAG_W  dispatched instruction.
REQ-016 ex_ready  in  1  ALU accepts dispatched instruction this cycle.

Function
REQ-017 Entry fields: busy, op, q1, v1, q2, v2, dest; operand N ready when qN == TAG_INVALID.
REQ-018 Issue accepted at posedge when issue_valid && !full; written to lowest-index non-busy entry.
REQ-019 full = all entries busy, from registered state only; slot freed by dispatch this cycle usable next cycle.
REQ-020 Wake-up: at posedge with cdb_valid, every busy entry with qN == cdb_tag (cdb_tag != TAG_INVALID) loads vN <= cdb_data, qN <= TAG_INVALID.
REQ-021 Issue bypass: if cdb_valid and issue_tagN == cdb_tag, issued entry stores cdb_data and TAG_INVALID for that operand.
REQ-022 Entry ready = busy && q1 == TAG_INVALID && q2 == TAG_INVALID, registered state only; wake-up visible one cycle after broadcast.
REQ-023 Select: ex_* driven combinationally from lowest-index ready entry; ex_valid=0 when none ready, ex_* then 0.
REQ-024 Dispatch when ex_valid && ex_ready; selected entry busy <= 0 at that posedge; ex_* stable while ex_valid && !ex_ready.
REQ-025 Issue and dispatch in same cycle both take effect; issue never targets the entry being dispatched.
REQ-026 flush has priority over issue, wake-up and dispatch: all busy <= 0, tags <= TAG_INVALID.
REQ-027 Both operands waiting on same tag wake together on one broadcast.

Reset
REQ-028 rst low: all busy=0, q1/q2=TAG_INVALID, v1/v2/op/dest=0 immediately; outputs full=0, ex_valid=0, ex_*=0.
REQ-029 Reset mid-operation discards all entries; first issue after release goes to entry 0.

Structure
REQ-030 DATA_W=32, TAG_W=4, TAG_INVALID=4'd0 and opcode encodings live in shared common_def package.
REQ-031 Entry record typedef lives in shared package.
REQ-032 One sub-module: rs_select, priority encoder returning lowest-index ready entry and a hit flag.

Verification
REQ-033 Issue op=ADD, tags 0, src1=5, src2=7, ex_ready=1 -> ex_valid next cycle, ex_a=5, ex_b=7, entry freed following edge.
REQ-034 Issue tag1=3, then cdb tag=3 data=0x10 -> ex_valid one cycle after broadcast, ex_a=0x10.
REQ-035 Issue tag2=5 same cycle as cdb tag=5 data=9 -> ex_valid next cycle, ex_b=9.
REQ-036 Issue 4 waiting instrs, ex_ready=0 -> full=1, 5th issue ignored; one dispatch -> full=0 next cycle, 5th lands in freed slot.
REQ-037 Entries 1 and 3 ready, entry 0 waiting -> entry 1 dispatched first, then entry 3.
REQ-038 3 busy entries, flush=1 with issue_valid=1 -> all busy=0, ex_valid=0, full=0; rst low mid-stream -> same, asynchronously.
